// File: rtl/rep3_serial_tx.sv
// Triple-repetition serial transmitter: start, DATA_W data bits LSB first, stop; each symbol sent as three chips.
// Define REP3_TX_PARITY_EN to insert an even-parity symbol between the data bits and the stop symbol.
module rep3_serial_tx #(
    parameter int unsigned DATA_W        = 8,
    parameter int unsigned CLKS_PER_CHIP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              tx_active,
    output logic              done
);

    localparam int unsigned DIV_W = (CLKS_PER_CHIP > 1) ? $clog2(CLKS_PER_CHIP) : 1;
    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLKS_PER_CHIP - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef REP3_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state, state_next;
    logic [DIV_W-1:0]  div_cnt, div_next;
    logic [1:0]        chip_cnt, chip_next;
    logic [IDX_W-1:0]  bit_idx, idx_next;
    logic [DATA_W-1:0] shreg, shreg_next, shreg_shift;
    logic              tx_next, active_next, done_next, ready_next;
    logic              sym_end;
`ifdef REP3_TX_PARITY_EN
    logic              par, par_next;
`endif

    // State and registered outputs; tx always comes straight from this flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            chip_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            tx        <= 1'b1;
            tx_active <= 1'b0;
            done      <= 1'b0;
            din_ready <= 1'b0;
`ifdef REP3_TX_PARITY_EN
            par       <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            div_cnt   <= div_next;
            chip_cnt  <= chip_next;
            bit_idx   <= idx_next;
            shreg     <= shreg_next;
            tx        <= tx_next;
            tx_active <= active_next;
            done      <= done_next;
            din_ready <= ready_next;
`ifdef REP3_TX_PARITY_EN
            par       <= par_next;
`endif
        end
    end

    assign sym_end     = (chip_cnt == 2'd2) && (div_cnt == DIV_MAX);
    assign shreg_shift = shreg >> 1;

    // Next state computes the value tx carries on the following cycle.
    always_comb begin
        state_next  = state;
        div_next    = div_cnt;
        chip_next   = chip_cnt;
        idx_next    = bit_idx;
        shreg_next  = shreg;
        tx_next     = tx;
        active_next = tx_active;
        done_next   = 1'b0;
        ready_next  = 1'b0;
`ifdef REP3_TX_PARITY_EN
        par_next    = par;
`endif

        if (state != IDLE) begin
            if (div_cnt == DIV_MAX) begin
                div_next  = '0;
                chip_next = (chip_cnt == 2'd2) ? 2'd0 : chip_cnt + 2'd1;
            end else begin
                div_next = div_cnt + DIV_W'(1);
            end
        end

        case (state)
            IDLE: begin
                tx_next     = 1'b1;
                active_next = 1'b0;
                ready_next  = 1'b1;
                if (din_valid && din_ready) begin
                    state_next  = START;
                    shreg_next  = din;
                    div_next    = '0;
                    chip_next   = '0;
                    idx_next    = '0;
                    tx_next     = 1'b0;
                    active_next = 1'b1;
                    ready_next  = 1'b0;
`ifdef REP3_TX_PARITY_EN
                    par_next    = ^din;
`endif
                end
            end
            START: begin
                if (sym_end) begin
                    state_next = DATA;
                    idx_next   = '0;
                    tx_next    = shreg[0];
                end
            end
            DATA: begin
                if (sym_end) begin
                    shreg_next = shreg_shift;
                    if (bit_idx == IDX_MAX) begin
                        idx_next = '0;
`ifdef REP3_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = par;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        idx_next = bit_idx + IDX_W'(1);
                        tx_next  = shreg_shift[0];
                    end
                end
            end
`ifdef REP3_TX_PARITY_EN
            PARITY: begin
                if (sym_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (sym_end) begin
                    state_next  = IDLE;
                    tx_next     = 1'b1;
                    active_next = 1'b0;
                    done_next   = 1'b1;
                    ready_next  = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                tx_next     = 1'b1;
                active_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rep3_serial_tx.sv
// Directed bench for rep3_serial_tx: framing, handshake, divider, reset abort and majority-vote loopback.
module tb_rep3_serial_tx;

`ifdef REP3_TX_PARITY_EN
    localparam int NSYM = 11;
`else
    localparam int NSYM = 10;
`endif
    localparam int FRAME  = 3 * NSYM;
    localparam int FRAME4 = 3 * NSYM * 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din, din4;
    logic       din_valid, din_valid4;
    logic       din_ready, tx, tx_active, done;
    logic       din_ready4, tx4, tx_active4, done4;

    int n_chk  = 0;
    int n_fail = 0;

    rep3_serial_tx #(.DATA_W(8), .CLKS_PER_CHIP(1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .tx_active(tx_active), .done(done)
    );

    rep3_serial_tx #(.DATA_W(8), .CLKS_PER_CHIP(4)) dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid4),
        .din_ready(din_ready4), .tx(tx4), .tx_active(tx_active4), .done(done4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Symbol s of a frame carrying word w.
    function automatic logic exp_sym(input logic [7:0] w, input int s);
        if (s == 0) return 1'b0;
        if (s <= 8) return w[s-1];
`ifdef REP3_TX_PARITY_EN
        if (s == 9) return ^w;
`endif
        return 1'b1;
    endfunction

    // Called on an idle cycle ("cycle 0"); returns on the done cycle.
    task automatic check_frame(input string tag, input logic [7:0] w,
                               input logic [7:0] next_w, input logic hold);
        din = w;
        din_valid = 1'b1;
        chk1({tag, "_ready_c0"}, din_ready, 1'b1);
        tick();
        din = next_w;
        din_valid = hold;
        for (int c = 1; c <= FRAME; c++) begin
            chk1($sformatf("%s_tx_c%0d", tag, c), tx, exp_sym(w, (c - 1) / 3));
            chk1($sformatf("%s_act_c%0d", tag, c), tx_active, 1'b1);
            chk1($sformatf("%s_rdy_c%0d", tag, c), din_ready, 1'b0);
            chk1($sformatf("%s_done_c%0d", tag, c), done, 1'b0);
            tick();
        end
        chk1({tag, "_done_end"}, done, 1'b1);
        chk1({tag, "_ready_end"}, din_ready, 1'b1);
        chk1({tag, "_tx_end"}, tx, 1'b1);
        chk1({tag, "_act_end"}, tx_active, 1'b0);
    endtask

    // Sends w, flips one chip per triplet in rotation, majority-decodes; returns on the done cycle.
    task automatic loop_frame(input logic [7:0] w, input int rot, output logic [7:0] rec);
        logic chips [0:FRAME-1];
        logic a, b, m;
        din = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            chips[c] = tx ^ ((c % 3) == ((c / 3 + rot) % 3));
            tick();
        end
        chk1("loop_done", done, 1'b1);
        rec = '0;
        for (int s = 0; s < NSYM; s++) begin
            a = chips[3*s];
            b = chips[3*s+1];
            m = (a & b) | (a & chips[3*s+2]) | (b & chips[3*s+2]);
            if (s >= 1 && s <= 8) rec[s-1] = m;
            else if (s == 0) chk1("loop_start_sym", m, 1'b0);
            else if (s == NSYM - 1) chk1("loop_stop_sym", m, 1'b1);
`ifdef REP3_TX_PARITY_EN
            else chk1("loop_parity_sym", m, ^w);
`endif
        end
    endtask

    initial begin
        logic [7:0] rec;
        logic [7:0] w;
        logic [29:0] a5_chips;

        rst = 1'b1;
        din = '0;
        din_valid = 1'b0;
        din4 = '0;
        din_valid4 = 1'b0;
        tick();
        tick();
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_act", tx_active, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_ready", din_ready, 1'b0);
        chk1("rst_ready4", din_ready4, 1'b0);
        rst = 1'b0;
        tick();
        chk1("ready_after_rst", din_ready, 1'b1);

        // Reset and din_valid together: reset wins.
        rst = 1'b1;
        din = 8'hFF;
        din_valid = 1'b1;
        tick();
        rst = 1'b0;
        din_valid = 1'b0;
        chk1("rstv_tx", tx, 1'b1);
        chk1("rstv_act", tx_active, 1'b0);
        chk1("rstv_ready", din_ready, 1'b0);
        tick();
        chk1("rstv_ready2", din_ready, 1'b1);
        tick();
        chk1("rstv_tx2", tx, 1'b1);
        chk1("rstv_act2", tx_active, 1'b0);

        // A5 literal chip pattern, checked alongside the model-based frame check.
        a5_chips = 30'b000111000111000000111000111111;
        din = 8'hA5;
        din_valid = 1'b1;
        tick();
        din = 8'h3C;
        for (int c = 1; c <= FRAME; c++) begin
`ifndef REP3_TX_PARITY_EN
            chk1($sformatf("a5_lit_c%0d", c), tx, a5_chips[30 - c]);
`endif
            chk1($sformatf("a5_tx_c%0d", c), tx, exp_sym(8'hA5, (c - 1) / 3));
            chk1($sformatf("a5_act_c%0d", c), tx_active, 1'b1);
            chk1($sformatf("a5_busy_rdy_c%0d", c), din_ready, 1'b0);
            chk1($sformatf("a5_done_c%0d", c), done, 1'b0);
            tick();
        end
        chk1("a5_done_end", done, 1'b1);
        chk1("a5_ready_end", din_ready, 1'b1);
        chk1("a5_tx_end", tx, 1'b1);

        // 3C, held valid throughout, is accepted on the done cycle.
        check_frame("f3c", 8'h3C, 8'h00, 1'b0);
        tick();
        chk1("done_one_cycle", done, 1'b0);
        chk1("idle_tx", tx, 1'b1);

        // Reset mid-frame at cycle 10.
        din = 8'hC3;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("abort_tx_c11", tx, 1'b1);
        chk1("abort_act_c11", tx_active, 1'b0);
        chk1("abort_ready_c11", din_ready, 1'b0);
        tick();
        chk1("abort_tx_c12", tx, 1'b1);
        chk1("abort_act_c12", tx_active, 1'b0);
        chk1("abort_ready_c12", din_ready, 1'b1);
        for (int c = 0; c < FRAME; c++) begin
            chk1("abort_no_done", done, 1'b0);
            tick();
        end
        check_frame("post_abort", 8'h96, 8'h00, 1'b0);

        // Divider: four cycles per chip.
        din4 = 8'h01;
        din_valid4 = 1'b1;
        chk1("div_ready_c0", din_ready4, 1'b1);
        tick();
        din_valid4 = 1'b0;
        for (int c = 1; c <= FRAME4; c++) begin
            chk1($sformatf("div_tx_c%0d", c), tx4, exp_sym(8'h01, (c - 1) / 12));
            chk1($sformatf("div_act_c%0d", c), tx_active4, 1'b1);
            chk1($sformatf("div_done_c%0d", c), done4, 1'b0);
            if (c == 12) chk1("div_last_start_chip", tx4, 1'b0);
            if (c == 13 || c == 24) chk1("div_first_data_chip", tx4, 1'b1);
            if (c == 25) chk1("div_second_data_chip", tx4, 1'b0);
            tick();
        end
        chk1("div_done_end", done4, 1'b1);
        chk1("div_act_end", tx_active4, 1'b0);

`ifdef REP3_TX_PARITY_EN
        // Parity: 07 has odd weight, so parity chips are 1 and done lands on cycle 34.
        check_frame("par07", 8'h07, 8'h00, 1'b0);
`endif

        // Loopback with one corrupted chip per triplet.
        for (int f = 0; f < 100; f++) begin
            case ($urandom_range(0, 2))
                0:       w = 8'h00;
                1:       w = 8'hFF;
                default: w = 8'h5A;
            endcase
            loop_frame(w, f % 3, rec);
            chk8($sformatf("loop_word_f%0d", f), rec, w);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
